// File: rtl/ext_pipe_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ext_pipe_unit_pkg
// Purpose  : Shared types and default widths for the operand extender and
//            its consumers (decode immediate path, writeback load path).
// Contents : ext_mode_t - extension mode encoding
//            DEF_IN_W / DEF_OUT_W / DEF_TAG_W - default widths
// Revision : 1.0 - initial release
// ============================================================================
package ext_pipe_unit_pkg;

  typedef enum logic [1:0] {
    EXT_ZERO  = 2'd0,
    EXT_SIGN  = 2'd1,
    EXT_UPPER = 2'd2,
    EXT_SBYTE = 2'd3
  } ext_mode_t;

  localparam int DEF_IN_W  = 16;
  localparam int DEF_OUT_W = 32;
  localparam int DEF_TAG_W = 5;

endpackage : ext_pipe_unit_pkg
`default_nettype wire

// File: rtl/ext_pipe_unit_ext_core.sv
`default_nettype none
// ============================================================================
// Module   : ext_core
// Purpose  : Purely combinational operand widener. Shared between the decode
//            immediate path and the writeback load path.
// Ports    : i_mode  - extension mode (ext_mode_t)
//            i_data  - IN_W-bit operand
//            o_data  - OUT_W-bit extended result
// Revision : 1.0 - initial release
// ============================================================================
module ext_core
  import ext_pipe_unit_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  ext_mode_t          i_mode,
  input  logic [IN_W-1:0]    i_data,
  output logic [OUT_W-1:0]   o_data
);

  always_comb begin
    o_data = '0;
    case (i_mode)
      EXT_ZERO:  o_data = {{(OUT_W-IN_W){1'b0}}, i_data};
      EXT_SIGN:  o_data = {{(OUT_W-IN_W){i_data[IN_W-1]}}, i_data};
      // LUI form; the concatenation is exactly OUT_W wide, so no truncation
      // is needed even when the operand is wider than the zero fill.
      EXT_UPPER: o_data = {i_data, {(OUT_W-IN_W){1'b0}}};
      EXT_SBYTE: o_data = {{(OUT_W-8){i_data[7]}}, i_data[7:0]};
      default:   o_data = '0;
    endcase
  end

endmodule : ext_core
`default_nettype wire

// File: rtl/ext_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module   : ext_pipe_unit
// Purpose  : Pipelined immediate/load-data extender with a 2-entry output
//            queue. in_ready depends only on registered occupancy, so a
//            consumer stall never reaches the producer combinationally.
// Ports    : clk, rst_n (async, active-low), flush (sync discard)
//            in_valid/in_ready, mode, data_in, tag_in   - producer side
//            out_valid/out_ready, data_out, tag_out      - consumer side
//            occupancy                                   - entries held (0..2)
// Revision : 1.0 - initial release
// ============================================================================
module ext_pipe_unit
  import ext_pipe_unit_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [IN_W-1:0]   data_in,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  data_out,
  output logic [TAG_W-1:0]  tag_out,
  output logic [1:0]        occupancy
);

  localparam int DEPTH = 2;

  logic [OUT_W-1:0] w_ext;
  logic             w_push;
  logic             w_pop;

  logic [OUT_W-1:0] r_data [DEPTH];
  logic [TAG_W-1:0] r_tag  [DEPTH];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_ext_core (
    .i_mode (ext_mode_t'(mode)),
    .i_data (data_in),
    .o_data (w_ext)
  );

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign data_out  = r_data[r_rd_ptr];
  assign tag_out   = r_tag[r_rd_ptr];
  assign occupancy = r_count;

  // Flush gates both handshakes so it overrides any concurrent transfer.
  assign w_push = in_valid  && in_ready  && !flush;
  assign w_pop  = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_tag[i]  <= '0;
      end
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_data[r_wr_ptr] <= w_ext;
        r_tag[r_wr_ptr]  <= tag_in;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : ext_pipe_unit
`default_nettype wire

// File: tb/tb_ext_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_pipe_unit
// Purpose  : Self-checking bench for ext_pipe_unit (IN_W=16, OUT_W=32,
//            TAG_W=5). Expected results go into a queue when an operand is
//            accepted and are compared when the unit presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ext_pipe_unit;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  t;
  } exp_t;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] din;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  mode = 2'd0;
  logic [15:0] data_in = '0;
  logic [4:0]  tag_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] data_out;
  logic [4:0]  tag_out;
  logic [1:0]  occupancy;

  int          checks = 0;
  int          failures = 0;
  int          pops = 0;
  int          exp_cnt = 0;
  logic [31:0] cur_exp = '0;
  exp_t        sb[$];
  vec_t        tbl[8];

  always #5 clk = ~clk;

  ext_pipe_unit #(
    .IN_W  (16),
    .OUT_W (32),
    .TAG_W (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .data_in   (data_in),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .tag_out   (tag_out),
    .occupancy (occupancy)
  );

  function automatic logic [31:0] ext_model(input logic [1:0] m, input logic [15:0] d);
    case (m)
      2'd0:    return {16'h0000, d};
      2'd1:    return {{16{d[15]}}, d};
      2'd2:    return {d, 16'h0000};
      default: return {{24{d[7]}}, d[7:0]};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] d,
                       input logic [4:0] t, input logic rdy);
    in_valid  = v;
    mode      = m;
    data_in   = d;
    tag_in    = t;
    out_ready = rdy;
    cur_exp   = ext_model(m, d);
  endtask

  // Called just after a rising edge with inputs already driven. Checks the
  // handshake state against the bench occupancy model, scores any pop, records
  // any push, then advances through the next rising edge.
  task automatic tick();
    exp_t e;
    logic exp_push;
    logic exp_pop;
    @(negedge clk);
    chk("occupancy", 32'(occupancy), 32'(exp_cnt));
    chk("in_ready",  32'(in_ready),  32'(exp_cnt != 2));
    chk("out_valid", 32'(out_valid), 32'(exp_cnt != 0));
    exp_push = in_valid && (exp_cnt != 2) && !flush;
    exp_pop  = (exp_cnt != 0) && out_ready && !flush;
    if (flush) begin
      sb.delete();
      exp_cnt = 0;
    end else begin
      if (exp_pop) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("data_out", data_out, e.d);
          chk("tag_out", 32'(tag_out), 32'(e.t));
          pops++;
        end
      end
      if (exp_push) begin
        e.d = cur_exp;
        e.t = tag_in;
        sb.push_back(e);
      end
      exp_cnt = exp_cnt + (exp_push ? 1 : 0) - (exp_pop ? 1 : 0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{2'd0, 16'h8001, 32'h00008001};
    tbl[1] = '{2'd1, 16'h8001, 32'hFFFF8001};
    tbl[2] = '{2'd2, 16'h8001, 32'h80010000};
    tbl[3] = '{2'd3, 16'h0080, 32'hFFFFFF80};
    tbl[4] = '{2'd1, 16'h7FFF, 32'h00007FFF};
    tbl[5] = '{2'd3, 16'h127F, 32'h0000007F};
    tbl[6] = '{2'd2, 16'h1234, 32'h12340000};
    tbl[7] = '{2'd0, 16'hFFFF, 32'h0000FFFF};

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_data_out",  data_out, 32'd0);
    chk("rst_tag_out",   32'(tag_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors, streamed back to back
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, tbl[i].mode, tbl[i].din, 5'(i + 1), 1'b1);
      cur_exp = tbl[i].exp;
      tick();
    end
    drive(1'b0, 2'd0, 16'h0, 5'd0, 1'b1);
    tick();
    chk("table_pops", 32'(pops), 32'd8);

    // Streaming: 10 operands, one result per cycle, occupancy held at 1
    pops = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'(i % 4), 16'(16'h1357 * (i + 3)), 5'(i + 10), 1'b1);
      tick();
      chk("stream_occ", 32'(occupancy), 32'd1);
      chk("stream_latency_valid", 32'(out_valid), 32'd1);
    end
    drive(1'b0, 2'd0, 16'h0, 5'd0, 1'b1);
    tick();
    chk("stream_pops", 32'(pops), 32'd10);

    // Backpressure: tags 3 then 7 with consumer stalled
    drive(1'b1, 2'd1, 16'hA5A5, 5'd3, 1'b0);
    tick();
    chk("bp_ready_after_1", 32'(in_ready), 32'd1);
    drive(1'b1, 2'd0, 16'h5A5A, 5'd7, 1'b0);
    tick();
    chk("bp_ready_after_2", 32'(in_ready), 32'd0);
    chk("bp_occ_2", 32'(occupancy), 32'd2);
    drive(1'b1, 2'd2, 16'h1111, 5'd8, 1'b0);
    tick();
    chk("bp_head_held", 32'(tag_out), 32'd3);
    drive(1'b0, 2'd0, 16'h0, 5'd0, 1'b1);
    tick();
    chk("bp_second_tag", 32'(tag_out), 32'd7);
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Push attempt at occupancy 2 with a pop: 2 -> 1 -> 2
    drive(1'b1, 2'd3, 16'h00F0, 5'd20, 1'b0);
    tick();
    drive(1'b1, 2'd3, 16'h0070, 5'd21, 1'b0);
    tick();
    drive(1'b1, 2'd1, 16'hC000, 5'd22, 1'b1);
    tick();
    chk("full_pop_occ", 32'(occupancy), 32'd1);
    drive(1'b1, 2'd1, 16'hC000, 5'd22, 1'b0);
    tick();
    chk("full_refill_occ", 32'(occupancy), 32'd2);
    drive(1'b0, 2'd0, 16'h0, 5'd0, 1'b1);
    tick();
    tick();
    chk("full_pops_tag22", 32'(occupancy), 32'd0);

    // Flush with two entries and a concurrent push
    drive(1'b1, 2'd0, 16'h2222, 5'd24, 1'b0);
    tick();
    drive(1'b1, 2'd0, 16'h3333, 5'd25, 1'b0);
    tick();
    drive(1'b1, 2'd0, 16'h4444, 5'd26, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_occ",       32'(occupancy), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready",  32'(in_ready),  32'd1);
    drive(1'b0, 2'd0, 16'h0, 5'd0, 1'b1);
    tick();

    // Asynchronous reset between edges with entries held
    drive(1'b1, 2'd1, 16'h9999, 5'd27, 1'b0);
    tick();
    drive(1'b0, 2'd0, 16'h0, 5'd0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_data_out",  data_out, 32'd0);
    chk("arst_occ",       32'(occupancy), 32'd0);
    sb.delete();
    exp_cnt = 0;
    #1;
    rst_n = 1'b1;
    drive(1'b1, 2'd2, 16'hBEEF, 5'd28, 1'b1);
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_data",  data_out, 32'hBEEF0000);
    drive(1'b0, 2'd0, 16'h0, 5'd0, 1'b1);
    tick();
    tick();
    chk("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule : tb_ext_pipe_unit
`default_nettype wire

// File: doc/ext_pipe_unit.md
# ext_pipe_unit

Parametrised, pipelined immediate/load-data extender for the decode and memory-writeback paths. It accepts a narrow operand with a mode and a destination tag over a valid/ready handshake, and computes the widened value: zero, sign, upper-placed, or byte-sign extension. Results are buffered in a 2-entry output queue so that downstream stalls never combinationally reach the producer. A synchronous flush discards everything in flight on a branch mispredict.

## Interface
- IN_W, 16, input operand width; must be ≥ 8 and < OUT_W
- OUT_W, 32, extended result width
- TAG_W, 5, sideband tag width (destination register index)
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- flush  in  1  synchronous discard of all buffered entries
- in_valid  in  1  producer offers an operand
- in_ready  out  1  unit can accept an operand this cycle
- mode  in  2  extension mode (EXT_ZERO, EXT_SIGN, EXT_UPPER, EXT_SBYTE)
- data_in  in  IN_W  operand
- tag_in  in  TAG_W  sideband tag
- out_valid  out  1  head entry is valid
- out_ready  in  1  consumer accepts the head entry
- data_out  out  OUT_W  extended result
- tag_out  out  TAG_W  tag of the head entry
- occupancy  out  2  number of buffered entries (0–2)

## Operation
- Extension (combinational on the input, then stored):
  - EXT_ZERO (0): {(OUT_W−IN_W) zeros, data_in}
  - EXT_SIGN (1): {(OUT_W−IN_W) copies of data_in[IN_W−1], data_in}
  - EXT_UPPER (2): {data_in, (OUT_W−IN_W) zeros}. This is the LUI form; when OUT_W−IN_W < IN_W, the low OUT_W bits of the concatenation are used.
  - EXT_SBYTE (3): {(OUT_W−8) copies of data_in[7], data_in[7:0]}
- Push occurs when in_valid && in_ready && !flush. Pop occurs when out_valid && out_ready && !flush.
- Buffer: 2-entry circular queue (rd_ptr, wr_ptr, count). Entries hold {data_out, tag}.
- in_ready = (count != 2). It is a registered-state function only and never depends on out_ready.
- out_valid = (count != 0). data_out/tag_out come from the rd_ptr entry, and are held stable while out_valid && !out_ready.
- Simultaneous push and pop at count 1: count stays 1, and both pointers advance.
- Count 2: in_ready is low and no push occurs, even if a pop happens that cycle. in_ready rises on the following cycle.
- Count 0 with push: the entry is visible the next cycle. There is no combinational bypass.
- Flush: count, rd_ptr and wr_ptr are cleared to 0. Any concurrent push or pop is ignored; flush takes priority.
- Reset: count = 0, pointers = 0, out_valid = 0, in_ready = 1 (combinational from count), occupancy = 0. data_out and tag_out read 0, because storage also resets to zero.
- Reset asserted mid-transfer drops all entries immediately and asynchronously.

## Timing
- Latency is 1 cycle: an operand accepted at edge N appears on data_out with out_valid after edge N.
- Throughput is 1 per cycle while out_ready stays high.
- With out_ready low, the queue fills in 2 cycles and in_ready falls after the second accepting edge.
- After flush is sampled at edge N: out_valid = 0 and in_ready = 1 from edge N onward.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.

## Structure
- A shared package holds:
  - ext_mode_t: the 2-bit enum EXT_ZERO/EXT_SIGN/EXT_UPPER/EXT_SBYTE
  - the default widths IN_W, OUT_W and TAG_W
- Sub-module ext_core: purely combinational mode → extended-value function, parametrised by IN_W and OUT_W. It is reused by the writeback load path.
- The top level holds the queue, pointers, count and handshake logic.

## Test plan
- Modes, with IN_W=16, OUT_W=32 and data_in 16'h8001:
  - ZERO → 32'h00008001
  - SIGN → 32'hFFFF8001
  - UPPER → 32'h80010000
  - SBYTE with 16'h0080 → 32'hFFFFFF80
- Backpressure: hold out_ready=0 and push tags 3, 7 → in_ready falls after the 2nd push and occupancy=2. Release out_ready → outputs appear in order, tag 3 then tag 7.
- Streaming: in_valid and out_ready held high for 10 cycles → 10 results, one per cycle, with 1-cycle latency. Occupancy stays at 1.
- Simultaneous push/pop at occupancy 2: in_valid stays high while one pop occurs → no push that cycle, and occupancy goes 2 → 1 → 2.
- Flush with 2 entries plus a concurrent push → the next cycle shows occupancy=0, out_valid=0 and in_ready=1. The pushed entry never appears.
- Asynchronous reset asserted mid-stream between edges → out_valid drops immediately and data_out reads 0. After release, the first new push appears 1 cycle after acceptance.
